// File: rtl/mips_alu_exec_unit.sv
// mips_alu_exec_unit
//   Execute-stage arithmetic block for the single-cycle MIPS-lite datapath:
//   ALU-control decoder, 32-bit ALU with zero/negative/carry flags, the
//   PC increment adder and the branch-target adder. All results are
//   combinational; a debug/pipeline register captures the ALU result and
//   flags when en is high.
//
// Ports
//   clk, reset            : rising-edge clock, asynchronous active-high reset
//   en                    : capture enable for the q_* result register
//   aluop1, aluop0        : operation class from main control
//   funct[3:0]            : R-type function bits (instruction[3:0])
//   immedateop[1:0]       : immediate-operation select from main control
//   a, b                  : ALU operands
//   pc, sextad            : current PC and shifted sign-extended offset
//   gout[2:0]             : decoded ALU select
//   alu_out, flagz/n, cout: combinational ALU result and flags
//   pcplus4, branchaddress: pc + PC_INC and pcplus4 + sextad
//   q_alu_out, q_flag*    : registered copies of the ALU result and flags

module mips_alu_exec_unit #(
  parameter logic [31:0] PC_INC = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        aluop1,
  input  logic        aluop0,
  input  logic [3:0]  funct,
  input  logic [1:0]  immedateop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] pc,
  input  logic [31:0] sextad,
  output logic [2:0]  gout,
  output logic [31:0] alu_out,
  output logic        flagz,
  output logic        flagn,
  output logic        cout,
  output logic [31:0] pcplus4,
  output logic [31:0] branchaddress,
  output logic [31:0] q_alu_out,
  output logic        q_flagz,
  output logic        q_flagn,
  output logic        q_cout
);

  typedef enum logic [2:0] {
    SEL_AND  = 3'b000,
    SEL_OR   = 3'b001,
    SEL_ADD  = 3'b010,
    SEL_XOR  = 3'b011,
    SEL_NOR  = 3'b100,
    SEL_NONE = 3'b101,
    SEL_SUB  = 3'b110,
    SEL_SLT  = 3'b111
  } alu_sel_e;

  alu_sel_e    sel;
  logic [32:0] add_full;
  logic [32:0] sub_full;

  // ALU-control decode.
  always_comb begin
    // NOTE: assigning a default first keeps this block free of inferred latches.
    sel = SEL_ADD;
    unique case ({aluop1, aluop0})
      2'b00: sel = SEL_ADD;
      2'b01: sel = SEL_SUB;
      2'b10: begin
        case (funct)
          4'b0000: sel = SEL_ADD;
          4'b0010: sel = SEL_SUB;
          4'b0100: sel = SEL_AND;
          4'b0101: sel = SEL_OR;
          4'b0110: sel = SEL_XOR;
          4'b0111: sel = SEL_NOR;
          4'b1010: sel = SEL_SLT;
          default: sel = SEL_ADD;
        endcase
      end
      2'b11: begin
        case (immedateop)
          2'b00: sel = SEL_ADD;
          2'b01: sel = SEL_AND;
          2'b10: sel = SEL_OR;
          2'b11: sel = SEL_SLT;
        endcase
      end
    endcase
  end

  assign gout = sel;

  // 33-bit sums expose the carry out of bit 31. Subtraction is a + ~b + 1,
  // so its carry is 1 exactly when a >= b unsigned.
  assign add_full = {1'b0, a} + {1'b0, b};
  assign sub_full = {1'b0, a} + {1'b0, ~b} + 33'd1;

  always_comb begin
    alu_out = '0;
    cout    = 1'b0;
    case (sel)
      SEL_AND: alu_out = a & b;
      SEL_OR:  alu_out = a | b;
      SEL_XOR: alu_out = a ^ b;
      SEL_NOR: alu_out = ~(a | b);
      SEL_ADD: {cout, alu_out} = add_full;
      SEL_SUB: {cout, alu_out} = sub_full;
      // Direct signed compare rather than the sign of a - b, so overflow
      // cannot flip the answer.
      SEL_SLT: alu_out = {31'd0, ($signed(a) < $signed(b))};
      default: alu_out = '0;
    endcase
  end

  assign flagz = (alu_out == 32'd0);
  assign flagn = alu_out[31];

  assign pcplus4       = pc + PC_INC;
  assign branchaddress = pcplus4 + sextad;

  // Result register; reset value represents an all-zero result.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      q_alu_out <= '0;
      q_flagz   <= 1'b1;
      q_flagn   <= 1'b0;
      q_cout    <= 1'b0;
    end else if (en) begin
      q_alu_out <= alu_out;
      q_flagz   <= flagz;
      q_flagn   <= flagn;
      q_cout    <= cout;
    end
  end

endmodule

// File: tb/tb_mips_alu_exec_unit.sv
// tb_mips_alu_exec_unit
//   Directed self-checking bench for mips_alu_exec_unit. Stimulus is applied
//   just after a falling edge; results are sampled 1 time unit later, well
//   away from the rising edge.

module tb_mips_alu_exec_unit;

  logic        clk;
  logic        reset;
  logic        en;
  logic        aluop1;
  logic        aluop0;
  logic [3:0]  funct;
  logic [1:0]  immedateop;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] pc;
  logic [31:0] sextad;
  logic [2:0]  gout;
  logic [31:0] alu_out;
  logic        flagz;
  logic        flagn;
  logic        cout;
  logic [31:0] pcplus4;
  logic [31:0] branchaddress;
  logic [31:0] q_alu_out;
  logic        q_flagz;
  logic        q_flagn;
  logic        q_cout;

  int n_checks = 0;
  int n_fails  = 0;

  mips_alu_exec_unit #(.PC_INC(32'd4)) dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .aluop1        (aluop1),
    .aluop0        (aluop0),
    .funct         (funct),
    .immedateop    (immedateop),
    .a             (a),
    .b             (b),
    .pc            (pc),
    .sextad        (sextad),
    .gout          (gout),
    .alu_out       (alu_out),
    .flagz         (flagz),
    .flagn         (flagn),
    .cout          (cout),
    .pcplus4       (pcplus4),
    .branchaddress (branchaddress),
    .q_alu_out     (q_alu_out),
    .q_flagz       (q_flagz),
    .q_flagn       (q_flagn),
    .q_cout        (q_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Apply one ALU vector just after a falling edge and let it settle.
  task automatic apply(input logic [1:0] op, input logic [3:0] fn,
                       input logic [1:0] imm, input logic [31:0] va,
                       input logic [31:0] vb);
    @(negedge clk);
    {aluop1, aluop0} = op;
    funct      = fn;
    immedateop = imm;
    a          = va;
    b          = vb;
    #1;
  endtask

  task automatic check_alu(input string tag, input logic [2:0] eg,
                           input logic [31:0] eo, input logic ez,
                           input logic en_flag, input logic ec);
    check({tag, ".gout"},  {29'd0, gout},  {29'd0, eg});
    check({tag, ".out"},   alu_out,        eo);
    check({tag, ".flagz"}, {31'd0, flagz}, {31'd0, ez});
    check({tag, ".flagn"}, {31'd0, flagn}, {31'd0, en_flag});
    check({tag, ".cout"},  {31'd0, cout},  {31'd0, ec});
  endtask

  task automatic check_q(input string tag, input logic [31:0] eo,
                         input logic ez, input logic en_flag, input logic ec);
    check({tag, ".q_out"},   q_alu_out,        eo);
    check({tag, ".q_flagz"}, {31'd0, q_flagz}, {31'd0, ez});
    check({tag, ".q_flagn"}, {31'd0, q_flagn}, {31'd0, en_flag});
    check({tag, ".q_cout"},  {31'd0, q_cout},  {31'd0, ec});
  endtask

  initial begin
    reset = 1'b1; en = 1'b1;
    aluop1 = 1'b0; aluop0 = 1'b0; funct = 4'd0; immedateop = 2'd0;
    a = 32'd0; b = 32'd0; pc = 32'd0; sextad = 32'd0;
    #2;
    check_q("reset_state", 32'd0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_q("reset_hold_edge", 32'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // R-add with wrap, then capture.
    apply(2'b10, 4'b0000, 2'b00, 32'hFFFF_FFFF, 32'h0000_0001);
    check_alu("r_add_wrap", 3'b010, 32'h0, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    check_q("r_add_capture", 32'h0, 1'b1, 1'b0, 1'b1);

    // Branch subtract, equal operands.
    apply(2'b01, 4'b0000, 2'b00, 32'd5, 32'd5);
    check_alu("beq_eq", 3'b110, 32'h0, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    check_q("beq_capture", 32'h0, 1'b1, 1'b0, 1'b1);

    // Branch subtract a < b; registers must hold while en is low.
    en = 1'b0;
    apply(2'b01, 4'b0000, 2'b00, 32'd3, 32'd5);
    check_alu("beq_lt", 3'b110, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    check_q("en_low_hold", 32'h0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    en = 1'b1;
    @(posedge clk); #1;
    check_q("en_high_capture", 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0);

    // R-type subtract, a >= b unsigned.
    apply(2'b10, 4'b0010, 2'b00, 32'h8000_0000, 32'h0000_0001);
    check_alu("r_sub", 3'b110, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);

    // slt, including cases where a - b overflows.
    apply(2'b10, 4'b1010, 2'b00, 32'h8000_0000, 32'h0000_0001);
    check_alu("slt_min_lt_1", 3'b111, 32'd1, 1'b0, 1'b0, 1'b0);
    apply(2'b10, 4'b1010, 2'b00, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    check_alu("slt_max_ge_m1", 3'b111, 32'd0, 1'b1, 1'b0, 1'b0);

    // Logical ops.
    apply(2'b10, 4'b0100, 2'b00, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    check_alu("and", 3'b000, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0);
    apply(2'b10, 4'b0101, 2'b00, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    check_alu("or", 3'b001, 32'hFFF0_FFF0, 1'b0, 1'b1, 1'b0);
    apply(2'b10, 4'b0111, 2'b00, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    check_alu("nor", 3'b100, 32'h000F_000F, 1'b0, 1'b0, 1'b0);
    apply(2'b10, 4'b0110, 2'b00, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    check_alu("xor", 3'b011, 32'hFF00_FF00, 1'b0, 1'b1, 1'b0);

    // Unlisted funct falls back to add.
    apply(2'b10, 4'b0001, 2'b00, 32'd1, 32'd2);
    check_alu("funct_default", 3'b010, 32'd3, 1'b0, 1'b0, 1'b0);

    // aluop 00 is add.
    apply(2'b00, 4'b0111, 2'b11, 32'h0000_0010, 32'h0000_0020);
    check_alu("aluop_add", 3'b010, 32'h0000_0030, 1'b0, 1'b0, 1'b0);

    // Immediate ops.
    apply(2'b11, 4'b0000, 2'b10, 32'h0000_0012, 32'h0000_0021);
    check_alu("ori", 3'b001, 32'h0000_0033, 1'b0, 1'b0, 1'b0);
    apply(2'b11, 4'b0000, 2'b11, 32'hFFFF_FFFE, 32'h0);
    check_alu("slti", 3'b111, 32'd1, 1'b0, 1'b0, 1'b0);
    apply(2'b11, 4'b0000, 2'b01, 32'h0000_00FF, 32'h0000_0F0F);
    check_alu("andi", 3'b000, 32'h0000_000F, 1'b0, 1'b0, 1'b0);
    apply(2'b11, 4'b0101, 2'b00, 32'h0000_0005, 32'hFFFF_FFFF);
    check_alu("addi", 3'b010, 32'h0000_0004, 1'b0, 1'b0, 1'b1);

    // PC adders, including wrap on both.
    @(negedge clk);
    pc = 32'h0000_0008; sextad = 32'hFFFF_FFF8;
    #1;
    check("pcplus4", pcplus4, 32'h0000_000C);
    check("branchaddress", branchaddress, 32'h0000_0004);
    pc = 32'hFFFF_FFFC; sextad = 32'h0000_0010;
    #1;
    check("pcplus4_wrap", pcplus4, 32'h0000_0000);
    check("branchaddress_wrap", branchaddress, 32'h0000_0010);

    // Asynchronous reset between edges with a nonzero value captured.
    apply(2'b00, 4'b0000, 2'b00, 32'h8000_0000, 32'h0000_0001);
    @(posedge clk); #1;
    check_q("pre_reset_capture", 32'h8000_0001, 1'b0, 1'b1, 1'b0);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    check_q("async_reset", 32'h0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_q("reset_wins_en", 32'h0, 1'b1, 1'b0, 1'b0);
    check("comb_indep_reset", alu_out, 32'h8000_0001);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_q("reset_release_no_edge", 32'h0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_q("first_capture_after_reset", 32'h8000_0001, 1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
